// File: rtl/mac_pkg.sv
// Shared types for the MAC sequencer: Q5.7 data width, fixed-point type and FSM states.
package mac_pkg;

  localparam int DATA_W = 12;

  typedef logic signed [DATA_W-1:0] fx_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BIAS  = 3'd1,
    ACC   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: feeds one neuron (bias, then N_INPUTS weight/input pairs) through an external MAC core.
// Build option MAC_SEQ_RELU_EN: negative accumulator values are clamped to zero when captured.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int  INT_BITS = 5,
  parameter int  FRC_BITS = 7,
  parameter int  N_INPUTS = 16,
  parameter int  ADDR_W   = 8,
  localparam int DW       = INT_BITS + FRC_BITS,
  localparam int XA_W     = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [DW-1:0]     result,
  output logic              w_rd,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [DW-1:0]     w_rdata,
  output logic              x_rd,
  output logic [XA_W-1:0]   x_addr,
  input  logic [DW-1:0]     x_rdata,
  output logic              mac_init,
  output logic              mac_en,
  output logic [DW-1:0]     mac_din,
  output logic [DW-1:0]     mac_w,
  input  logic [DW-1:0]     mac_acc
);

  localparam int                CNT_W = $clog2(N_INPUTS + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_INPUTS);

  seq_state_t        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]     result_q, result_d;
  logic              bias_vld_q, elem_vld_q;
  logic              rd_elem;
  logic [DW-1:0]     acc_post;

  // cnt_q counts element reads issued; it reaches LAST in the final mac_en cycle
  assign rd_elem = (state_q == ACC) && (cnt_q != LAST);

`ifdef MAC_SEQ_RELU_EN
  assign acc_post = mac_acc[DW-1] ? '0 : mac_acc;
`else
  assign acc_post = mac_acc;
`endif

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = BIAS;
          base_d  = base_addr;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BIAS: state_d = ACC;
      ACC: begin
        if (rd_elem) cnt_d = cnt_q + CNT_W'(1);
        else         state_d = DRAIN;
      end
      DRAIN: begin
        result_d = acc_post;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      bias_vld_q <= 1'b0;
      elem_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      // memory data returns one cycle after the strobe, so the MAC controls trail the reads by one
      bias_vld_q <= (state_q == BIAS);
      elem_vld_q <= rd_elem;
    end
  end

  assign busy     = (state_q == BIAS) || (state_q == ACC) || (state_q == DRAIN);
  assign done     = (state_q == DONE);
  assign result   = result_q;

  assign w_rd     = (state_q == BIAS) || rd_elem;
  assign w_addr   = (state_q == BIAS) ? base_q :
                    rd_elem           ? base_q + ADDR_W'(cnt_q) + ADDR_W'(1) : '0;
  assign x_rd     = rd_elem;
  assign x_addr   = rd_elem ? cnt_q[XA_W-1:0] : '0;

  assign mac_init = bias_vld_q;
  assign mac_en   = elem_vld_q;
  assign mac_din  = x_rdata;
  assign mac_w    = w_rdata;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl with a behavioural MAC core and synchronous-read memories.
module tb_mac_seq_ctrl;

  localparam int FRC_BITS = 7;
  localparam int DW       = 12;
  localparam int N        = 4;
  localparam int AW       = 8;
  localparam int XW       = 2;
`ifdef MAC_SEQ_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          busy, done;
  logic [DW-1:0] result;
  logic          w_rd, x_rd;
  logic [AW-1:0] w_addr;
  logic [XW-1:0] x_addr;
  logic [DW-1:0] w_rdata, x_rdata;
  logic          mac_init, mac_en;
  logic [DW-1:0] mac_din, mac_w, mac_acc;

  always #5 clk = ~clk;

  mac_seq_ctrl #(.INT_BITS(5), .FRC_BITS(FRC_BITS), .N_INPUTS(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .result(result),
    .w_rd(w_rd), .w_addr(w_addr), .w_rdata(w_rdata),
    .x_rd(x_rd), .x_addr(x_addr), .x_rdata(x_rdata),
    .mac_init(mac_init), .mac_en(mac_en), .mac_din(mac_din), .mac_w(mac_w),
    .mac_acc(mac_acc)
  );

  // memories with one-cycle read latency
  logic [DW-1:0] wmem [256];
  logic [DW-1:0] xmem [N];
  always @(posedge clk) begin
    if (w_rd) w_rdata <= wmem[w_addr];
    if (x_rd) x_rdata <= xmem[x_addr];
  end

  // MAC core: load bias, or add (din*w) scaled back to Q5.7, wrapping
  logic signed [2*DW-1:0] prod;
  assign prod = $signed(mac_din) * $signed(mac_w);
  always @(posedge clk) begin
    if (!rst_n)        mac_acc <= '0;
    else if (mac_init) mac_acc <= mac_w;
    else if (mac_en)   mac_acc <= mac_acc + DW'(prod >>> FRC_BITS);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int init_q[$], en_q[$], done_q[$], wa_q[$], xa_q[$];
  logic [DW-1:0] res_q[$];
  int viol = 0;
  always @(negedge clk) begin
    if (mac_init) init_q.push_back(cyc);
    if (mac_en)   en_q.push_back(cyc);
    if (done) begin
      done_q.push_back(cyc);
      res_q.push_back(result);
    end
    if (w_rd) wa_q.push_back(int'(w_addr));
    if (x_rd) xa_q.push_back(int'(x_addr));
    if ((mac_init && mac_en) || (done && busy)) viol <= viol + 1;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    init_q.delete(); en_q.delete(); done_q.delete();
    wa_q.delete(); xa_q.delete(); res_q.delete();
  endtask

  logic [DW-1:0] cur_bias;
  logic [DW-1:0] cur_w [N];
  logic [DW-1:0] cur_x [N];

  task automatic set_uniform(input logic [DW-1:0] b, input logic [DW-1:0] wv, input logic [DW-1:0] xv);
    cur_bias = b;
    for (int i = 0; i < N; i++) begin
      cur_w[i] = wv;
      cur_x[i] = xv;
    end
  endtask

  task automatic load(input logic [AW-1:0] base);
    logic [AW-1:0] a;
    wmem[base] = cur_bias;
    for (int i = 0; i < N; i++) begin
      a = AW'(int'(base) + 1 + i);
      wmem[a] = cur_w[i];
      xmem[i] = cur_x[i];
    end
  endtask

  function automatic int sx(input logic [DW-1:0] v);
    return int'($signed(v));
  endfunction

  // neuron = bias + sum of (x*w scaled by 2^-FRC), kept modulo 2^DW
  function automatic logic [DW-1:0] ref_result();
    int s;
    logic [31:0] t;
    logic [DW-1:0] r;
    s = sx(cur_bias);
    for (int i = 0; i < N; i++) s += (sx(cur_x[i]) * sx(cur_w[i])) >>> FRC_BITS;
    t = s;
    r = t[DW-1:0];
    if (RELU && r[DW-1]) r = '0;
    return r;
  endfunction

  task automatic run_check(input string tag, input logic [AW-1:0] base, input logic [DW-1:0] exp);
    int c0;
    bit ok;
    clear_logs();
    base_addr = base;
    start = 1'b1;
    c0 = cyc;
    tick();
    start = 1'b0;
    base_addr = AW'($urandom);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (done_q.size() > 0) ok = 1'b1;
      else tick();
    end
    check({tag, " done_seen"}, int'(ok), 1);
    if (ok) begin
      check({tag, " done_cycle"}, done_q[0] - c0, N + 4);
      check({tag, " result"}, int'(res_q[0]), int'(exp));
    end
    check({tag, " init_count"}, init_q.size(), 1);
    if (init_q.size() == 1) check({tag, " init_cycle"}, init_q[0] - c0, 2);
    check({tag, " en_count"}, en_q.size(), N);
    if (en_q.size() == N) begin
      check({tag, " en_first"}, en_q[0] - c0, 3);
      check({tag, " en_last"}, en_q[N-1] - c0, N + 2);
    end
    check({tag, " bias_addr"}, (wa_q.size() > 0) ? wa_q[0] : -1, int'(base));
    check({tag, " busy_after"}, int'(busy), 0);
    $display("run %s base=%02h result=%03h expected=%03h", tag, base, result, exp);
  endtask

  typedef struct packed {
    logic [AW-1:0] base;
    logic [DW-1:0] bias;
    logic [DW-1:0] wv;
    logic [DW-1:0] xv;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t tbl [5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    tbl[0] = '{8'h10, 12'h080, 12'h080, 12'h100, 12'h480};
    tbl[1] = '{8'h20, 12'hF80, 12'h080, 12'h000, RELU ? 12'h000 : 12'hF80};
    tbl[2] = '{8'h30, 12'h000, 12'hF80, 12'h100, RELU ? 12'h000 : 12'hC00};
    tbl[3] = '{8'h40, 12'h100, 12'h040, 12'h040, 12'h180};
    tbl[4] = '{8'hFE, 12'h080, 12'h080, 12'h100, 12'h480};

    // reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset busy", int'(busy), 0);
    check("reset done", int'(done), 0);
    check("reset result", int'(result), 0);
    check("reset strobes", int'({w_rd, x_rd, mac_init, mac_en}), 0);
    rst_n = 1'b1;
    tick();

    // directed vectors; the last one exercises weight-address wrap
    for (int v = 0; v < 5; v++) begin
      set_uniform(tbl[v].bias, tbl[v].wv, tbl[v].xv);
      load(tbl[v].base);
      run_check($sformatf("vec%0d", v), tbl[v].base, tbl[v].exp);
      check($sformatf("vec%0d ref_model", v), int'(ref_result()), int'(tbl[v].exp));
    end
    check("wrap w_count", wa_q.size(), N + 1);
    if (wa_q.size() == N + 1)
      for (int k = 0; k <= N; k++) check($sformatf("wrap w_addr%0d", k), wa_q[k], (8'hFE + k) % 256);
    check("wrap x_count", xa_q.size(), N);
    if (xa_q.size() == N)
      for (int k = 0; k < N; k++) check($sformatf("wrap x_addr%0d", k), xa_q[k], k);
    repeat (3) tick();
    check("result_held", int'(result), 12'h480);

    // start pulses during a run are ignored
    set_uniform(12'h080, 12'h080, 12'h100);
    load(8'h10);
    clear_logs();
    base_addr = 8'h10; start = 1'b1; c0 = cyc;
    tick(); start = 1'b0;
    tick(); tick();
    start = 1'b1; base_addr = 8'h77; tick(); start = 1'b0;
    tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (20) tick();
    check("ignore done_count", done_q.size(), 1);
    check("ignore init_count", init_q.size(), 1);
    if (done_q.size() == 1) begin
      check("ignore done_cycle", done_q[0] - c0, N + 4);
      check("ignore result", int'(res_q[0]), 12'h480);
    end
    $display("run ignore_start dones=%0d result=%03h", done_q.size(), result);

    // reset asserted mid-run
    clear_logs();
    base_addr = 8'h10; start = 1'b1; c0 = cyc;
    tick(); start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    check("abort result", int'(result), 0);
    check("abort strobes", int'({w_rd, x_rd, mac_init, mac_en}), 0);
    tick();
    rst_n = 1'b1;
    repeat (15) tick();
    check("abort no_done", done_q.size(), 0);
    $display("run abort cycle=%0d dones=%0d", cyc - c0, done_q.size());
    run_check("post_abort", 8'h10, 12'h480);

    // start held across done: back-to-back neurons
    clear_logs();
    base_addr = 8'h10; start = 1'b1; c0 = cyc;
    repeat (N + 5) tick();
    start = 1'b0;
    repeat (N + 12) tick();
    check("b2b done_count", done_q.size(), 2);
    if (done_q.size() == 2) begin
      check("b2b first_done", done_q[0] - c0, N + 4);
      check("b2b spacing", done_q[1] - done_q[0], N + 4);
      check("b2b result1", int'(res_q[1]), 12'h480);
    end
    $display("run back_to_back dones=%0d", done_q.size());

    // randomized neurons against the reference model
    for (int r = 0; r < 25; r++) begin
      logic [AW-1:0] b;
      b = AW'($urandom);
      cur_bias = DW'($urandom);
      for (int i = 0; i < N; i++) begin
        cur_w[i] = DW'($urandom);
        cur_x[i] = DW'($urandom);
      end
      load(b);
      run_check($sformatf("rand%0d", r), b, ref_result());
      repeat ($urandom_range(0, 3)) tick();
    end

    check("init_en_exclusive", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
